// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display controller.
// Also holds the double-dabble nibble-adjust step used by the BCD engine.
package clock_display_pkg;

    typedef enum logic [1:0] {
        HHMMSS = 2'd0,
        YYMMDD = 2'd1,
        YYYYMM = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        COMMIT
    } state_t;

    localparam logic [3:0] PORT_SEC   = 4'd0;
    localparam logic [3:0] PORT_MIN   = 4'd1;
    localparam logic [3:0] PORT_HOUR  = 4'd2;
    localparam logic [3:0] PORT_DAY   = 4'd3;
    localparam logic [3:0] PORT_MONTH = 4'd4;
    localparam logic [3:0] PORT_YEAR  = 4'd5;

    localparam int SHIFT_CYCLES = 16;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one bit per cycle into five BCD nibbles.
// done pulses for one cycle once the last shift has landed in bcd.
module bin2bcd_seq
    import clock_display_pkg::*;
#(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [19:0]      bcd
);

    logic [BIN_W-1:0] sh_bin;
    logic [19:0]      sh_bcd;
    logic [19:0]      adj_bcd;
    logic [4:0]       cnt;
    logic             run;

    assign adj_bcd = dd_adjust(sh_bcd);
    assign bcd     = sh_bcd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_bin <= '0;
            sh_bcd <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                sh_bin <= bin;
                sh_bcd <= '0;
                cnt    <= '0;
                run    <= 1'b1;
            end else if (run) begin
                sh_bcd <= {adj_bcd[18:0], sh_bin[BIN_W-1]};
                sh_bin <= {sh_bin[BIN_W-2:0], 1'b0};
                cnt    <= cnt + 1'b1;
                if (cnt == 5'(BIN_W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_display_ctrl.sv
// Captures time/date port writes, debounces mode buttons, and converts the
// selected fields to BCD one at a time, committing all six digits at once.
module clock_display_ctrl
    import clock_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int BIN_W           = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        write_out,
    input  logic [3:0]  out_port,
    input  logic [15:0] out_data,
    input  logic        btn_hhmmss,
    input  logic        btn_yymmdd,
    input  logic        btn_yyyymm,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [3:0]  digit5,
    output logic [1:0]  mode,
    output logic        busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [7:0]  sec_r, min_r, hour_r, day_r, month_r;
    logic [15:0] year_r;
    logic        valid_wr;

    assign valid_wr = write_out && (out_port <= PORT_YEAR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sec_r <= '0; min_r <= '0; hour_r <= '0;
            day_r <= '0; month_r <= '0; year_r <= '0;
        end else if (write_out) begin
            case (out_port)
                PORT_SEC:   sec_r   <= out_data[7:0];
                PORT_MIN:   min_r   <= out_data[7:0];
                PORT_HOUR:  hour_r  <= out_data[7:0];
                PORT_DAY:   day_r   <= out_data[7:0];
                PORT_MONTH: month_r <= out_data[7:0];
                PORT_YEAR:  year_r  <= out_data;
                default: ;
            endcase
        end
    end

    // Bit 0 hhmmss, bit 1 yymmdd, bit 2 yyyymm; lower index wins on ties.
    logic [2:0] btn_raw;
    logic [2:0] acc;
    assign btn_raw = {btn_yyyymm, btn_yymmdd, btn_hhmmss};

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic [1:0]      sync;
        logic [DB_W-1:0] cnt;
        logic            acc_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync  <= '0;
                cnt   <= '0;
                acc_q <= 1'b0;
            end else begin
                sync  <= {sync[0], btn_raw[g]};
                acc_q <= sync[1] && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
                if (!sync[1])                            cnt <= '0;
                else if (cnt != DB_W'(DEBOUNCE_CYCLES))  cnt <= cnt + 1'b1;
            end
        end

        assign acc[g] = acc_q;
    end

    mode_t  mode_r, mode_lat;
    state_t state, state_nx;
    logic   dirty;

    assign mode = mode_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_r <= HHMMSS;
            dirty  <= 1'b0;
        end else begin
            if (acc[0])      mode_r <= HHMMSS;
            else if (acc[1]) mode_r <= YYMMDD;
            else if (acc[2]) mode_r <= YYYYMM;
            // New work arriving on the edge that starts a run must not be lost.
            if (valid_wr || (|acc)) dirty <= 1'b1;
            else if (state == IDLE) dirty <= 1'b0;
        end
    end

    logic [1:0]       fidx;
    logic [4:0]       scnt;
    logic             last_field;
    logic             eng_start, eng_done;
    logic [BIN_W-1:0] eng_bin;
    logic [19:0]      eng_bcd;
    logic [5:0][3:0]  shadow, shadow_nx, digits;

    assign last_field = (mode_lat == YYYYMM) ? (fidx == 2'd1) : (fidx == 2'd2);

    bin2bcd_seq #(.BIN_W(BIN_W)) u_bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (eng_start),
        .bin   (eng_bin),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    always_comb begin
        eng_bin = '0;
        if (mode_lat == HHMMSS) begin
            case (fidx)
                2'd0:    eng_bin = BIN_W'(hour_r);
                2'd1:    eng_bin = BIN_W'(min_r);
                default: eng_bin = BIN_W'(sec_r);
            endcase
        end else begin
            case (fidx)
                2'd0:    eng_bin = BIN_W'(year_r);
                2'd1:    eng_bin = BIN_W'(month_r);
                default: eng_bin = BIN_W'(day_r);
            endcase
        end
    end

    // Two-digit fields keep only tens/ones, which is exactly value mod 100.
    always_comb begin
        shadow_nx = shadow;
        if (mode_lat == YYYYMM) begin
            if (fidx == 2'd0) shadow_nx[5:2] = eng_bcd[15:0];
            else              shadow_nx[1:0] = eng_bcd[7:0];
        end else begin
            case (fidx)
                2'd0:    shadow_nx[5:4] = eng_bcd[7:0];
                2'd1:    shadow_nx[3:2] = eng_bcd[7:0];
                default: shadow_nx[1:0] = eng_bcd[7:0];
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        case (state)
            IDLE:   if (dirty) state_nx = LOAD;
            LOAD: begin
                eng_start = 1'b1;
                state_nx  = SHIFT;
            end
            SHIFT:  if (scnt == 5'(SHIFT_CYCLES - 1)) state_nx = STORE;
            STORE:  state_nx = last_field ? COMMIT : LOAD;
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            fidx     <= '0;
            scnt     <= '0;
            mode_lat <= HHMMSS;
            busy     <= 1'b0;
            shadow   <= '0;
            digits   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (dirty) begin
                    fidx     <= '0;
                    mode_lat <= mode_r;
                    busy     <= 1'b1;
                end
                LOAD:  scnt <= '0;
                SHIFT: scnt <= scnt + 1'b1;
                STORE: begin
                    if (eng_done) shadow <= shadow_nx;
                    fidx <= fidx + 1'b1;
                end
                COMMIT: begin
                    digits <= shadow;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];
    assign digit4 = digits[4];
    assign digit5 = digits[5];

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Bench for clock_display_ctrl: vector table, hand-written corner sequences,
// and randomized writes/presses checked against a decimal-arithmetic model.
module tb_clock_display_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        write_out = 1'b0;
    logic [3:0]  out_port = '0;
    logic [15:0] out_data = '0;
    logic        btn_hhmmss = 1'b0, btn_yymmdd = 1'b0, btn_yyyymm = 1'b0;
    logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5;
    logic [1:0]  mode;
    logic        busy;

    always #5 clk = ~clk;

    clock_display_ctrl #(.DEBOUNCE_CYCLES(DB), .BIN_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .write_out  (write_out),
        .out_port   (out_port),
        .out_data   (out_data),
        .btn_hhmmss (btn_hhmmss),
        .btn_yymmdd (btn_yymmdd),
        .btn_yyyymm (btn_yyyymm),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .digit5     (digit5),
        .mode       (mode),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: field values as the program last wrote them, and mode.
    int m_sec = 0, m_min = 0, m_hour = 0, m_day = 0, m_month = 0, m_year = 0, m_mode = 0;

    typedef struct {
        logic [3:0]  port;
        logic [15:0] data;
        logic        exp_busy;
        logic [23:0] exp_dig;
    } vec_t;

    vec_t tv [8];

    function automatic logic [7:0] two(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] model_digits();
        case (m_mode)
            0:       return {two(m_hour), two(m_min), two(m_sec)};
            1:       return {two(m_year), two(m_month), two(m_day)};
            default: return {4'((m_year / 1000) % 10), 4'((m_year / 100) % 10), two(m_year), two(m_month)};
        endcase
    endfunction

    function automatic logic [23:0] dut_digits();
        return {digit5, digit4, digit3, digit2, digit1, digit0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] port, input logic [15:0] data);
        write_out = 1'b1;
        out_port  = port;
        out_data  = data;
        @(negedge clk);
        write_out = 1'b0;
        case (port)
            4'd0: m_sec   = int'(data[7:0]);
            4'd1: m_min   = int'(data[7:0]);
            4'd2: m_hour  = int'(data[7:0]);
            4'd3: m_day   = int'(data[7:0]);
            4'd4: m_month = int'(data[7:0]);
            4'd5: m_year  = int'(data);
            default: ;
        endcase
    endtask

    // mask: bit0 hhmmss, bit1 yymmdd, bit2 yyyymm; held n cycles then released.
    task automatic press(input logic [2:0] mask, input int n);
        btn_hhmmss = mask[0];
        btn_yymmdd = mask[1];
        btn_yyyymm = mask[2];
        cyc(n);
        btn_hhmmss = 1'b0;
        btn_yymmdd = 1'b0;
        btn_yyyymm = 1'b0;
        cyc(3);
        if (n >= DB) begin
            if (mask[0])      m_mode = 0;
            else if (mask[1]) m_mode = 1;
            else if (mask[2]) m_mode = 2;
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (busy !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (k >= max) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, busy, max);
        end
    endtask

    task automatic busy_watch(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        tv[0] = '{4'd0, 16'd7,     1'b1, 24'h000007};
        tv[1] = '{4'd1, 16'd59,    1'b1, 24'h005907};
        tv[2] = '{4'd2, 16'd23,    1'b1, 24'h235907};
        tv[3] = '{4'd0, 16'h01FF,  1'b1, 24'h235955};
        tv[4] = '{4'd2, 16'd100,   1'b1, 24'h005955};
        tv[5] = '{4'd1, 16'hAB12,  1'b1, 24'h001855};
        tv[6] = '{4'd9, 16'h1234,  1'b0, 24'h001855};
        tv[7] = '{4'd3, 16'd31,    1'b1, 24'h001855};

        // Reset state
        cyc(3);
        rstn = 1'b1;
        cyc(1);
        check("reset digits", dut_digits(), 24'h0);
        check("reset mode", mode, 0);
        check("reset busy", busy, 0);
        busy_watch("idle busy 200", 200);

        // Table of single writes in HHMMSS mode
        for (int i = 0; i < 8; i++) begin
            wr(tv[i].port, tv[i].data);
            cyc(1);
            check($sformatf("vec%0d busy", i), busy, tv[i].exp_busy);
            cyc(70);
            check($sformatf("vec%0d digits", i), dut_digits(), tv[i].exp_dig);
            check($sformatf("vec%0d model", i), dut_digits(), model_digits());
        end

        // Exact latency: dirty at E0, commit at E0+56 for three fields
        wr(4'd0, 16'd42);
        cyc(55);
        check("lat E0+55 digits", dut_digits(), 24'h001855);
        check("lat E0+55 busy", busy, 1);
        cyc(1);
        check("lat E0+56 digits", dut_digits(), 24'h001842);
        check("lat E0+56 busy", busy, 0);

        // Back-to-back writes
        wr(4'd2, 16'd23);
        wr(4'd1, 16'd59);
        wr(4'd0, 16'd7);
        cyc(130);
        check("b2b digits", dut_digits(), 24'h235907);
        check("b2b busy", busy, 0);

        // Debounce: short press ignored, long press selects YYYYMM
        wr(4'd5, 16'd2023);
        wr(4'd4, 16'd1);
        cyc(130);
        press(3'b100, 3);
        cyc(20);
        check("short press mode", mode, 0);
        check("short press busy", busy, 0);
        press(3'b100, 6);
        cyc(60);
        check("long press mode", mode, 2);
        check("yyyymm digits", dut_digits(), 24'h202301);

        // Max year, then an out-of-range port write
        wr(4'd5, 16'hFFFF);
        cyc(50);
        check("year 65535 digits", dut_digits(), 24'h553501);
        wr(4'd7, 16'h1234);
        busy_watch("port7 busy", 20);
        check("port7 digits", dut_digits(), 24'h553501);

        // Writes during a run trigger an immediate second run
        press(3'b001, 6);
        cyc(70);
        check("hhmmss return", dut_digits(), model_digits());
        wr(4'd0, 16'd1);
        cyc(9);
        wr(4'd1, 16'd30);
        wr(4'd1, 16'd45);
        wait_idle("run1 end", 100);
        cyc(1);
        check("rerun busy", busy, 1);
        wait_idle("run2 end", 100);
        check("rerun digits", dut_digits(), 24'h234501);
        check("rerun minutes", {digit3, digit2}, 8'h45);

        // Simultaneous accepts: hhmmss wins
        press(3'b100, 6);
        cyc(60);
        check("pre-tie mode", mode, 2);
        press(3'b101, 6);
        cyc(70);
        check("tie mode", mode, 0);
        press(3'b010, 6);
        cyc(70);
        check("yymmdd mode", mode, 1);
        check("yymmdd digits", dut_digits(), 24'h350131);

        // Reset in the middle of a run
        wr(4'd3, 16'd5);
        cyc(20);
        check("midrun busy", busy, 1);
        rstn = 1'b0;
        cyc(2);
        check("midrun rst digits", dut_digits(), 24'h0);
        check("midrun rst busy", busy, 0);
        check("midrun rst mode", mode, 0);
        rstn = 1'b1;
        m_sec = 0; m_min = 0; m_hour = 0; m_day = 0; m_month = 0; m_year = 0; m_mode = 0;
        busy_watch("post-rst busy", 100);
        check("post-rst digits", dut_digits(), 24'h0);

        // Randomized writes and presses against the model
        for (int b = 0; b < 12; b++) begin
            int nact = $urandom_range(1, 4);
            for (int a = 0; a < nact; a++) begin
                if ($urandom_range(0, 3) != 0) begin
                    wr(4'($urandom_range(0, 15)), 16'($urandom));
                end else begin
                    press(3'($urandom_range(1, 7)), $urandom_range(2, 7));
                end
                cyc($urandom_range(0, 5));
            end
            cyc(260);
            check($sformatf("rand%0d digits", b), dut_digits(), model_digits());
            check($sformatf("rand%0d mode", b), mode, m_mode);
            check($sformatf("rand%0d busy", b), busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
